slave_fifo_tx_arbiter: RTL and testbench
========================================

Name: slave_fifo_tx_arbiter

Overview:
- Shares the single slave-FIFO write path (EP6, FIFOADR 2'b10) among N message sources, e.g. one serializer-side message FIFO per channel.
- Picks one requesting channel at a time, round-robin, and emits a framed message on a valid/ready word stream. The stream feeds the slave-FIFO read/write sequencer.
- Each message is framed as: prefix word, source/length header word, then the payload words pulled from the granted channel's show-ahead FIFO.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- PREFIX, 16'hBBBB, first word of every message
- MAX_LEN, 255, largest legal payload length in words (8-bit length field)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- REQ  in  N_CH  channel i holds at least one complete message (its GOT_FULL_MSG)
- LEN  in  8*N_CH  payload length of channel i's pending message, slice [8i+7:8i]
- CH_Q  in  16*N_CH  show-ahead FIFO output of channel i
- CH_RD  out  N_CH  read request to channel i's FIFO, one word per asserted cycle
- OUT_DATA  out  16  word to the slave-FIFO sequencer
- OUT_VALID  out  1  OUT_DATA is valid
- OUT_READY  in  1  sequencer accepts the word this cycle (it has done an SLWR strobe)
- OUT_LAST  out  1  marks the final word of the message; the sequencer may issue PKTEND on it
- GRANT  out  N_CH  one-hot owner of the current message; all zeros when idle
- BUSY  out  1  a message is in flight (state other than IDLE)
- ZERO_LEN  out  1  one-cycle pulse when a granted message has LEN==0
- state_monitor  out  3  current state encoding
- msg_counter  out  8  count of completed messages, wraps at 255->0

Behaviour:
- Reset values:
  - state IDLE; rr pointer 0; GRANT 0.
  - OUT_VALID, OUT_LAST, BUSY, ZERO_LEN, CH_RD all 0; OUT_DATA 0; msg_counter 0.
- States: IDLE(0), PREFIX(1), HEADER(2), PAYLOAD(3), GAP(4). Other codes go to IDLE.
- Handshake: a word transfers on any cycle with OUT_VALID & OUT_READY. OUT_DATA and OUT_LAST hold stable while OUT_VALID=1 and OUT_READY=0.
- IDLE:
  - If REQ!=0, choose the first set bit searching upward from the rr pointer, wrapping.
  - Register GRANT, register len_reg=LEN[sel], go to PREFIX. The grant appears the cycle after REQ is seen.
- PREFIX:
  - OUT_VALID=1, OUT_DATA=PREFIX.
  - On transfer go to HEADER.
- HEADER:
  - OUT_VALID=1, OUT_DATA={5'b0, src_id[2:0], len_reg}.
  - If len_reg==0: OUT_LAST=1, pulse ZERO_LEN on entry, and go to GAP on transfer.
  - Otherwise go to PAYLOAD on transfer; word counter = 0.
- PAYLOAD:
  - OUT_VALID=1, OUT_DATA=CH_Q[granted slice].
  - CH_RD[granted] = OUT_VALID & OUT_READY, combinational, so there is exactly one FIFO pop per transferred word.
  - Counter increments on each transfer. OUT_LAST=1 when counter==len_reg-1.
  - The last transfer goes to GAP.
- GAP:
  - One cycle with OUT_VALID=0.
  - msg_counter increments.
  - rr pointer = granted index+1, wrapping modulo N_CH.
  - GRANT clears; go to IDLE.
- Back-to-back messages therefore have a minimum gap of 2 cycles with OUT_VALID=0 (GAP, then IDLE). This gives the sequencer room for PKTEND.
- Length is sampled once at grant. Later changes on LEN[sel] are ignored for that message.
- REQ[sel] deasserting mid-message is ignored; the message always completes.
- Simultaneous REQ from all channels: served in rotating order starting from the rr pointer. No channel waits more than N_CH-1 messages.
- Synchronous RST mid-message:
  - Returns to IDLE next edge and drops OUT_VALID and CH_RD immediately.
  - The partially sent message is abandoned. Channel FIFO flushing is the owner's responsibility.
- Arithmetic: the word counter is 8 bits; len_reg up to 255 never wraps the counter. src_id = binary encoding of GRANT.

Decomposition:
- Shared package: state encodings (ST_IDLE..ST_GAP), PREFIX constant, header field widths (SRC_W=3, LEN_W=8).
- One natural sub-module: rr_priority_picker.
  - Inputs: REQ, rr pointer. Outputs: one-hot grant, binary index.
  - Purely combinational, N_CH parameterised.

Test Plan:
- REQ=4'b0001, LEN0=3, CH_Q0 sequence 0x1111/0x2222/0x3333, OUT_READY=1:
  - Expect BBBB, 0x0003, 1111, 2222, 3333, with OUT_LAST on 3333.
  - Expect CH_RD0 high exactly 3 cycles; msg_counter=1.
- Same message with OUT_READY toggling 1,0,0,1:
  - Words hold stable while stalled; no duplicate or dropped words.
  - CH_RD0 pulses only on accepted payload cycles.
- REQ=4'b1111 held, every LEN=1:
  - Grant order 0,1,2,3,0.
  - Header src_id fields 0,1,2,3,0; GAP/IDLE between each message.
- REQ=4'b0100, LEN2=0:
  - Only BBBB then 0x0200 with OUT_LAST=1; ZERO_LEN pulses once.
  - CH_RD never asserts.
- LEN1=255:
  - 257 words total; OUT_LAST on word 257; counter does not wrap.
- RST=1 during payload word 2 of a 5-word message:
  - Next cycle state_monitor=0, OUT_VALID=0, GRANT=0, rr pointer=0.
  - The next REQ restarts cleanly with a PREFIX word.

Source files
------------

// File: rtl/slave_fifo_tx_arbiter_pkg.sv
// Shared definitions for the slave-FIFO transmit arbiter.
//   - state_t     : message framing FSM states
//   - PREFIX_WORD : default first word of every framed message
//   - SRC_W/LEN_W : header field widths (source id, payload length)
//   - make_header : builds the {pad, src_id, len} header word
package slave_fifo_tx_arbiter_pkg;

  localparam int unsigned SRC_W = 3;
  localparam int unsigned LEN_W = 8;
  localparam logic [15:0] PREFIX_WORD = 16'hBBBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFIX  = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  function automatic logic [15:0] make_header(input logic [SRC_W-1:0] src,
                                              input logic [LEN_W-1:0] len);
    return {{(16 - SRC_W - LEN_W){1'b0}}, src, len};
  endfunction

endpackage

// File: rtl/slave_fifo_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   i_req   : per-channel request vector
//   i_ptr   : channel index with highest priority this round
//   o_grant : one-hot chosen channel (zero when no request)
//   o_idx   : binary index of the chosen channel
module rr_priority_picker
  import slave_fifo_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N_CH-1:0]  o_grant,
  output logic [SRC_W-1:0] o_idx
);

  logic [N_CH-1:0] w_mask;
  logic [N_CH-1:0] w_hi;
  logic [N_CH-1:0] w_pick;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_mask[i] = (i >= 32'(i_ptr));
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    w_hi    = i_req & w_mask;
    w_pick  = (w_hi != '0) ? w_hi : i_req;
    // Isolate the lowest set bit.
    o_grant = w_pick & (~w_pick + N_CH'(1));
    o_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (o_grant[i]) o_idx = SRC_W'(i);
    end
  end

endmodule

// File: rtl/slave_fifo_tx_arbiter.sv
// Shares the EP6 slave-FIFO write path among N_CH message sources.
// One requesting channel is granted round-robin and its message is framed as
// PREFIX word, {src_id, len} header word, then len payload words popped from
// the channel's show-ahead FIFO, on a valid/ready stream.
//   CLK, RST        : clock, synchronous active-high reset
//   REQ/LEN/CH_Q    : per-channel request, pending length, FIFO head word
//   CH_RD           : per-channel FIFO pop, one per accepted payload word
//   OUT_DATA/VALID/READY/LAST : framed word stream to the sequencer
//   GRANT, BUSY, ZERO_LEN, state_monitor, msg_counter : status
module slave_fifo_tx_arbiter
  import slave_fifo_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter logic [15:0] PREFIX  = PREFIX_WORD,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_CH-1:0]     REQ,
  input  logic [8*N_CH-1:0]   LEN,
  input  logic [16*N_CH-1:0]  CH_Q,
  output logic [N_CH-1:0]     CH_RD,
  output logic [15:0]         OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_LAST,
  output logic [N_CH-1:0]     GRANT,
  output logic                BUSY,
  output logic                ZERO_LEN,
  output logic [2:0]          state_monitor,
  output logic [7:0]          msg_counter
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  state_t             r_state;
  state_t             w_next;
  logic [N_CH-1:0]    r_grant;
  logic [SRC_W-1:0]   r_src;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic [SRC_W-1:0]   r_ptr;
  logic [7:0]         r_msg_cnt;
  logic               r_zero_len;

  logic [N_CH-1:0]    w_pick_grant;
  logic [SRC_W-1:0]   w_pick_idx;
  logic [LEN_W-1:0]   w_len_sel;
  logic [15:0]        w_ch_q;
  logic               w_xfer;
  logic               w_pay_last;

  rr_priority_picker #(
    .N_CH(N_CH)
  ) u_picker (
    .i_req  (REQ),
    .i_ptr  (r_ptr),
    .o_grant(w_pick_grant),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_len_sel = '0;
    w_ch_q    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_pick_idx == SRC_W'(i)) w_len_sel = LEN[8*i +: 8];
      if (r_src == SRC_W'(i))      w_ch_q    = CH_Q[16*i +: 16];
    end
  end

  assign w_xfer     = OUT_VALID & OUT_READY;
  assign w_pay_last = (r_state == ST_PAYLOAD) && (r_cnt == CNT_W'(r_len - LEN_W'(1)));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (REQ != '0) w_next = ST_PREFIX;
      ST_PREFIX:  if (w_xfer) w_next = ST_HEADER;
      ST_HEADER:  if (w_xfer) w_next = (r_len == '0) ? ST_GAP : ST_PAYLOAD;
      ST_PAYLOAD: if (w_xfer && w_pay_last) w_next = ST_GAP;
      ST_GAP:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output logic; reset masks the stream at once rather than at the next edge.
  assign OUT_VALID = (r_state inside {ST_PREFIX, ST_HEADER, ST_PAYLOAD}) && !RST;
  assign CH_RD     = (r_state == ST_PAYLOAD && w_xfer) ? r_grant : '0;

  always_comb begin
    OUT_DATA = '0;
    OUT_LAST = 1'b0;
    case (r_state)
      ST_PREFIX:  OUT_DATA = PREFIX;
      ST_HEADER: begin
        OUT_DATA = make_header(r_src, r_len);
        OUT_LAST = (r_len == '0) && !RST;
      end
      ST_PAYLOAD: begin
        OUT_DATA = w_ch_q;
        OUT_LAST = w_pay_last && !RST;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant    <= '0;
      r_src      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_msg_cnt  <= '0;
      r_zero_len <= 1'b0;
    end else begin
      r_zero_len <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (REQ != '0) begin
            r_grant <= w_pick_grant;
            r_src   <= w_pick_idx;
            r_len   <= w_len_sel;
          end
        end
        // Pulse lands on the first HEADER cycle only, even if that word stalls.
        ST_PREFIX:  if (w_xfer) r_zero_len <= (r_len == '0);
        ST_HEADER:  if (w_xfer) r_cnt <= '0;
        ST_PAYLOAD: if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
        ST_GAP: begin
          r_msg_cnt <= r_msg_cnt + 8'd1;
          r_ptr     <= (32'(r_src) == N_CH - 1) ? '0 : r_src + SRC_W'(1);
          r_grant   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign GRANT         = r_grant;
  assign BUSY          = (r_state != ST_IDLE);
  assign ZERO_LEN      = r_zero_len;
  assign state_monitor = r_state;
  assign msg_counter   = r_msg_cnt;

endmodule

// File: tb/tb_slave_fifo_tx_arbiter.sv
`timescale 1ns/1ps
module tb_slave_fifo_tx_arbiter;

  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [8*N-1:0]  LEN;
  logic [16*N-1:0] CH_Q;
  logic [N-1:0]    CH_RD;
  logic [15:0]     OUT_DATA;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic            OUT_LAST;
  logic [N-1:0]    GRANT;
  logic            BUSY;
  logic            ZERO_LEN;
  logic [2:0]      state_monitor;
  logic [7:0]      msg_counter;

  always #5 CLK = ~CLK;

  slave_fifo_tx_arbiter #(
    .N_CH(N),
    .PREFIX(16'hBBBB),
    .MAX_LEN(255)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LEN(LEN), .CH_Q(CH_Q), .CH_RD(CH_RD),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .GRANT(GRANT), .BUSY(BUSY), .ZERO_LEN(ZERO_LEN),
    .state_monitor(state_monitor), .msg_counter(msg_counter)
  );

  // ---------------- channel FIFO environment ----------------
  logic [15:0] fmem [N][0:511];
  int          fwr [N];
  int          frd [N];
  int          mrd [N];       // model-side read pointer
  logic [7:0]  len_cfg [N];

  always_comb begin
    CH_Q = '0;
    LEN  = '0;
    for (int c = 0; c < N; c++) begin
      CH_Q[16*c +: 16] = (frd[c] < fwr[c]) ? fmem[c][frd[c]] : 16'h0000;
      LEN[8*c +: 8]    = len_cfg[c];
    end
  end

  always @(posedge CLK) begin
    for (int c = 0; c < N; c++) if (CH_RD[c]) frd[c] <= frd[c] + 1;
  end

  task automatic push(input int c, input logic [15:0] d);
    fmem[c][fwr[c]] = d;
    fwr[c]++;
  endtask

  // ---------------- ready driver ----------------
  bit [3:0] rdy_pat = 4'b1111;
  int       rdy_idx = 0;
  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      OUT_READY = rdy_pat[rdy_idx % 4];
      rdy_idx++;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    bit          last;
    int          ch;
    bit          pay;
    bit          first;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] log_data[$];
  bit          log_last[$];
  int          m_ptr = 0, m_msgs = 0, m_zero = 0;
  int          msgs_started = 0, pay_seen = 0, z_seen = 0;
  int          rd_cycles [N];
  bit          in_rst = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  int          gap_left = 0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // Expected word stream for nmsg messages while req is held.
  task automatic plan(input logic [N-1:0] req, input int nmsg);
    word_t w;
    int s, l;
    for (int m = 0; m < nmsg; m++) begin
      s = pick(req, m_ptr);
      l = int'(len_cfg[s]);
      w.ch = s; w.pay = 0; w.first = 1; w.last = 0; w.data = 16'hBBBB;
      exp_q.push_back(w);
      w.first = 0; w.last = (l == 0);
      w.data = (16'(s) << 8) | 16'(l);
      exp_q.push_back(w);
      for (int i = 0; i < l; i++) begin
        w.pay = 1; w.last = (i == l - 1);
        w.data = fmem[s][mrd[s] + i];
        exp_q.push_back(w);
      end
      mrd[s] += l;
      m_ptr = (s + 1) % N;
      m_msgs++;
      if (l == 0) m_zero++;
    end
  endtask

  always @(negedge CLK) begin
    if (in_rst) begin
      chk("rst_valid", 32'(OUT_VALID), 0);
      chk("rst_ch_rd", 32'(CH_RD), 0);
      prev_stall = 0;
      gap_left   = 0;
    end else begin
      if (ZERO_LEN) z_seen++;
      for (int c = 0; c < N; c++) if (CH_RD[c]) rd_cycles[c]++;
      if (prev_stall) begin
        chk("stall_valid", 32'(OUT_VALID), 1);
        chk("stall_data", 32'(OUT_DATA), 32'(prev_data));
        chk("stall_last", 32'(OUT_LAST), 32'(prev_last));
      end
      if (gap_left > 0) begin
        chk("gap_valid", 32'(OUT_VALID), 0);
        gap_left--;
      end
      if (!BUSY) chk("idle_grant", 32'(GRANT), 0);
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(OUT_VALID), 0);
        end else begin
          chk("grant", 32'(GRANT), 32'(1) << exp_q[0].ch);
          if (OUT_READY) begin
            chk("data", 32'(OUT_DATA), 32'(exp_q[0].data));
            chk("last", 32'(OUT_LAST), 32'(exp_q[0].last));
            chk("ch_rd", 32'(CH_RD), exp_q[0].pay ? (32'(1) << exp_q[0].ch) : 32'(0));
            if (exp_q[0].first) msgs_started++;
            if (exp_q[0].pay) pay_seen++;
            if (exp_q[0].last) gap_left = 2;
            log_data.push_back(OUT_DATA);
            log_last.push_back(OUT_LAST);
            void'(exp_q.pop_front());
          end else begin
            chk("stall_ch_rd", 32'(CH_RD), 0);
          end
        end
      end else begin
        chk("idle_ch_rd", 32'(CH_RD), 0);
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_last  = OUT_LAST;
    end
  end

  task automatic run(input logic [N-1:0] req, input int nmsg);
    int start, cyc;
    start = msgs_started;
    log_data.delete();
    log_last.delete();
    for (int c = 0; c < N; c++) rd_cycles[c] = 0;
    plan(req, nmsg);
    @(posedge CLK); #1;
    REQ = req;
    cyc = 0;
    while (msgs_started < start + nmsg && cyc < 3000) begin
      @(posedge CLK); #1; cyc++;
    end
    REQ = '0;
    cyc = 0;
    while ((exp_q.size() != 0 || BUSY) && cyc < 3000) begin
      @(posedge CLK); #1; cyc++;
    end
    chk("msgs_started", 32'(msgs_started - start), 32'(nmsg));
    chk("drain_left", 32'(exp_q.size()), 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("msg_counter", 32'(msg_counter), 32'(m_msgs % 256));
    chk("zero_len_total", 32'(z_seen), 32'(m_zero));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, cyc, z0;
    for (int c = 0; c < N; c++) begin
      fwr[c] = 0; frd[c] = 0; mrd[c] = 0; len_cfg[c] = 8'd0; rd_cycles[c] = 0;
    end
    RST = 1'b1;
    REQ = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", 32'(state_monitor), 0);
    chk("reset_valid", 32'(OUT_VALID), 0);
    chk("reset_last", 32'(OUT_LAST), 0);
    chk("reset_grant", 32'(GRANT), 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_zero_len", 32'(ZERO_LEN), 0);
    chk("reset_ch_rd", 32'(CH_RD), 0);
    chk("reset_data", 32'(OUT_DATA), 0);
    chk("reset_msg_counter", 32'(msg_counter), 0);
    RST = 1'b0;
    in_rst = 1'b0;

    // T1: single 3-word message from channel 0, always ready
    len_cfg[0] = 8'd3;
    push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333);
    run(4'b0001, 1);
    chk("t1_words", 32'(log_data.size()), 5);
    if (log_data.size() == 5) begin
      chk("t1_w0", 32'(log_data[0]), 32'hBBBB);
      chk("t1_w1", 32'(log_data[1]), 32'h0003);
      chk("t1_w2", 32'(log_data[2]), 32'h1111);
      chk("t1_w4", 32'(log_data[4]), 32'h3333);
      chk("t1_last4", 32'(log_last[4]), 1);
      chk("t1_last3", 32'(log_last[3]), 0);
    end
    chk("t1_rd_cycles", 32'(rd_cycles[0]), 3);
    chk("t1_msg_counter", 32'(msg_counter), 1);

    // T2: same message with ready toggling 1,0,0,1
    push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333);
    rdy_pat = 4'b1001; rdy_idx = 0;
    run(4'b0001, 1);
    rdy_pat = 4'b1111;
    chk("t2_words", 32'(log_data.size()), 5);
    if (log_data.size() == 5) begin
      chk("t2_w3", 32'(log_data[3]), 32'h2222);
      chk("t2_w4", 32'(log_data[4]), 32'h3333);
    end
    chk("t2_rd_cycles", 32'(rd_cycles[0]), 3);
    chk("t2_msg_counter", 32'(msg_counter), 2);

    // T3: reset while channel 2's 5-word message is on payload word 2
    len_cfg[2] = 8'd5;
    for (int i = 0; i < 5; i++) push(2, 16'h5000 + 16'(i));
    plan(4'b0100, 1);
    base = pay_seen;
    @(posedge CLK); #1;
    REQ = 4'b0100;
    cyc = 0;
    while (pay_seen < base + 1 && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
    end
    chk("t3_first_payload", 32'(pay_seen - base), 1);
    RST = 1'b1; in_rst = 1'b1; REQ = '0;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("t3_rst_state", 32'(state_monitor), 0);
    chk("t3_rst_valid", 32'(OUT_VALID), 0);
    chk("t3_rst_grant", 32'(GRANT), 0);
    chk("t3_rst_msg_counter", 32'(msg_counter), 0);
    RST = 1'b0; in_rst = 1'b0;
    m_ptr = 0; m_msgs = 0;
    fwr[2] = frd[2]; mrd[2] = frd[2];

    // T4: all channels requesting, LEN=1 each; restart must begin at channel 0
    for (int c = 0; c < N; c++) len_cfg[c] = 8'd1;
    push(0, 16'hA000); push(1, 16'hA001); push(2, 16'hA002); push(3, 16'hA003); push(0, 16'hA004);
    run(4'b1111, 5);
    chk("t4_words", 32'(log_data.size()), 15);
    if (log_data.size() == 15) begin
      chk("t4_restart_prefix", 32'(log_data[0]), 32'hBBBB);
      chk("t4_hdr0", 32'(log_data[1]), 32'h0001);
      chk("t4_hdr1", 32'(log_data[4]), 32'h0101);
      chk("t4_hdr2", 32'(log_data[7]), 32'h0201);
      chk("t4_hdr3", 32'(log_data[10]), 32'h0301);
      chk("t4_hdr4", 32'(log_data[13]), 32'h0001);
      chk("t4_pay4", 32'(log_data[14]), 32'hA004);
    end

    // T5: zero-length message from channel 2
    len_cfg[2] = 8'd0;
    z0 = z_seen;
    run(4'b0100, 1);
    chk("t5_words", 32'(log_data.size()), 2);
    if (log_data.size() == 2) begin
      chk("t5_hdr", 32'(log_data[1]), 32'h0200);
      chk("t5_last", 32'(log_last[1]), 1);
    end
    chk("t5_zero_pulses", 32'(z_seen - z0), 1);
    chk("t5_rd_cycles", 32'(rd_cycles[2]), 0);

    // T6: maximum length 255 from channel 1
    len_cfg[1] = 8'd255;
    for (int i = 0; i < 255; i++) push(1, 16'h1000 + 16'(i));
    run(4'b0010, 1);
    chk("t6_words", 32'(log_data.size()), 257);
    if (log_data.size() == 257) begin
      chk("t6_hdr", 32'(log_data[1]), 32'h01FF);
      chk("t6_final", 32'(log_data[256]), 32'h10FE);
      chk("t6_last256", 32'(log_last[256]), 1);
      chk("t6_last255", 32'(log_last[255]), 0);
    end
    chk("t6_rd_cycles", 32'(rd_cycles[1]), 255);
    chk("t6_msg_counter", 32'(msg_counter), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
